// File: rtl/cc1200_spi_apb_if.sv
// APB3 bus bundle for the CC1200 SPI bridge.
// The master modport drives requests and the slave modport returns data and ready.
interface cc1200_spi_apb_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/cc1200_spi_apb_top.sv
// APB3 slave with a byte-oriented mode-0 SPI master for the CC1200 and a 4-bit GPIO port.
// Start latches TXDATA/NBYTE/CLKDIV so that register writes during a transfer leave it untouched.
module cc1200_spi_apb_top (
    input  logic                    clk,
    input  logic                    rstn,
    cc1200_spi_apb_if.slave         APB_S_0,
    inout  wire  [3:0]              GPIO,
    output logic                    SCLK,
    output logic                    MOSI,
    input  logic                    MISO,
    output logic                    CS_n
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

    state_t      state_r;
    logic [31:0] txdata_r, rxdata_r, tx_shift_r;
    logic [1:0]  nbyte_r;
    logic [15:0] clkdiv_r, half_r, div_cnt_r;
    logic [5:0]  bit_cnt_r;
    logic [3:0]  gpio_oe_r, gpio_out_r, gpio_meta_r, gpio_sync_r;
    logic        busy_r, sclk_r, mosi_r, cs_n_r;

    logic [3:0]  reg_idx_s;
    logic        wr_en_s, start_s, half_end_s, unused_s;
    logic [31:0] tx_align_s, prdata_s;
    logic [4:0]  tx_shamt_s;
    logic [5:0]  len_s;

    assign reg_idx_s  = APB_S_0.paddr[5:2];
    assign unused_s   = ^{APB_S_0.paddr[31:6], APB_S_0.paddr[1:0]};
    assign wr_en_s    = APB_S_0.psel & APB_S_0.penable & APB_S_0.pwrite;
    assign start_s    = wr_en_s && (reg_idx_s == 4'd0) && APB_S_0.pwdata[0] && !busy_r;
    assign tx_shamt_s = {(2'd3 - nbyte_r), 3'b000};
    assign tx_align_s = txdata_r << tx_shamt_s;
    assign len_s      = {({1'b0, nbyte_r} + 3'd1), 3'b000};
    assign half_end_s = (div_cnt_r == (half_r - 16'd1));

    assign APB_S_0.pready  = APB_S_0.psel & APB_S_0.penable;
    assign APB_S_0.pslverr = 1'b0;
    assign APB_S_0.prdata  = prdata_s;

    assign SCLK = sclk_r;
    assign MOSI = mosi_r;
    assign CS_n = cs_n_r;

    for (genvar i = 0; i < 4; i++) begin : g_gpio
        assign GPIO[i] = gpio_oe_r[i] ? gpio_out_r[i] : 1'bz;
    end

    // Read mux: combinational from the address while selected.
    always_comb begin
        prdata_s = 32'd0;
        if (APB_S_0.psel) begin
            case (reg_idx_s)
                4'd1:    prdata_s = {31'd0, busy_r};
                4'd2:    prdata_s = txdata_r;
                4'd3:    prdata_s = rxdata_r;
                4'd4:    prdata_s = {30'd0, nbyte_r};
                4'd5:    prdata_s = {16'd0, clkdiv_r};
                4'd6:    prdata_s = {28'd0, gpio_oe_r};
                4'd7:    prdata_s = {28'd0, gpio_out_r};
                4'd8:    prdata_s = {28'd0, gpio_sync_r};
                default: prdata_s = 32'd0;
            endcase
        end else begin
            prdata_s = 32'd0;
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txdata_r   <= 32'd0;
            nbyte_r    <= 2'd0;
            clkdiv_r   <= 16'd4;
            gpio_oe_r  <= 4'd0;
            gpio_out_r <= 4'd0;
        end else if (wr_en_s) begin
            case (reg_idx_s)
                4'd2:    txdata_r   <= APB_S_0.pwdata;
                4'd4:    nbyte_r    <= APB_S_0.pwdata[1:0];
                4'd5:    clkdiv_r   <= APB_S_0.pwdata[15:0];
                4'd6:    gpio_oe_r  <= APB_S_0.pwdata[3:0];
                4'd7:    gpio_out_r <= APB_S_0.pwdata[3:0];
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser for the GPIO pin values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpio_meta_r <= 4'd0;
            gpio_sync_r <= 4'd0;
        end else begin
            gpio_meta_r <= GPIO;
            gpio_sync_r <= gpio_meta_r;
        end
    end

    // SPI sequencer: every state step is one SCLK half-period of half_r clocks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            tx_shift_r <= 32'd0;
            rxdata_r   <= 32'd0;
            half_r     <= 16'd1;
            div_cnt_r  <= 16'd0;
            bit_cnt_r  <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        tx_shift_r <= tx_align_s;
                        mosi_r     <= tx_align_s[31];
                        bit_cnt_r  <= len_s;
                        half_r     <= (clkdiv_r == 16'd0) ? 16'd1 : clkdiv_r;
                        div_cnt_r  <= 16'd0;
                        rxdata_r   <= 32'd0;
                        cs_n_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (half_end_s) begin
                        div_cnt_r <= 16'd0;
                        sclk_r    <= 1'b1;
                        rxdata_r  <= {rxdata_r[30:0], MISO};
                        state_r   <= ST_SHIFT;
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (half_end_s) begin
                        div_cnt_r <= 16'd0;
                        if (sclk_r) begin
                            sclk_r    <= 1'b0;
                            bit_cnt_r <= bit_cnt_r - 6'd1;
                            if (bit_cnt_r == 6'd1) begin
                                state_r <= ST_HOLD;
                            end else begin
                                tx_shift_r <= {tx_shift_r[30:0], 1'b0};
                                mosi_r     <= tx_shift_r[30];
                            end
                        end else begin
                            sclk_r   <= 1'b1;
                            rxdata_r <= {rxdata_r[30:0], MISO};
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (half_end_s) begin
                        div_cnt_r <= 16'd0;
                        cs_n_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        mosi_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cc1200_spi_apb_top.sv
// Bench for cc1200_spi_apb_top: APB register access, GPIO and SPI transfers.
// Expected MOSI bits are queued at stimulus time and compared against bits captured on SCLK rising.
module tb_cc1200_spi_apb_top;
    logic        clk;
    logic        rstn;
    wire  [3:0]  gpio;
    wire         sclk, mosi, cs_n;
    logic        miso;
    logic        ext_en;
    logic [3:0]  ext_val;
    logic [31:0] miso_pat;

    int checks   = 0;
    int failures = 0;
    bit exp_q[$];
    bit act_q[$];

    cc1200_spi_apb_if apb();

    cc1200_spi_apb_top dut (
        .clk     (clk),
        .rstn    (rstn),
        .APB_S_0 (apb),
        .GPIO    (gpio),
        .SCLK    (sclk),
        .MOSI    (mosi),
        .MISO    (miso),
        .CS_n    (cs_n)
    );

    assign gpio = ext_en ? ext_val : 4'bzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MISO model: rotating pattern, MSB presented at CS_n fall and advanced on SCLK falling.
    always @(negedge cs_n) miso = miso_pat[31];
    always @(negedge sclk) begin
        miso_pat = {miso_pat[30:0], miso_pat[31]};
        miso     = miso_pat[31];
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        apb.paddr = a; apb.pwdata = d; apb.pwrite = 1'b1; apb.psel = 1'b1; apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        apb.paddr = a; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        #2 d = apb.prdata;
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic prep_xfer(input logic [15:0] div, input logic [1:0] nb,
                             input logic [31:0] tx, input logic [31:0] pat);
        int len;
        apb_write(32'h14, {16'd0, div});
        apb_write(32'h10, {30'd0, nb});
        apb_write(32'h08, tx);
        miso_pat = pat;
        len = 8 * (int'(nb) + 1);
        exp_q.delete();
        act_q.delete();
        for (int i = len - 1; i >= 0; i--) exp_q.push_back(tx[i]);
    endtask

    task automatic watch_xfer(input int budget, input int tail, output int rises, output int windows,
                              output int min_p, output int max_p, output bit timed_out);
        int cyc = 0;
        int last_rise = -1;
        int tail_left = tail;
        bit prev_s = 1'b0;
        bit prev_cs = 1'b1;
        bit done = 1'b0;
        rises = 0; windows = 0; min_p = 1000000; max_p = 0; timed_out = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (!cs_n && prev_cs) windows++;
            if (sclk && !prev_s) begin
                rises++;
                act_q.push_back(mosi);
                if (last_rise >= 0) begin
                    if (cyc - last_rise < min_p) min_p = cyc - last_rise;
                    if (cyc - last_rise > max_p) max_p = cyc - last_rise;
                end
                last_rise = cyc;
            end
            if (cs_n && !prev_cs) done = 1'b1;
            prev_s = sclk;
            prev_cs = cs_n;
            if (done) begin
                if (tail_left == 0) break;
                tail_left--;
            end
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        rstn = 1'b1;
        apb_read(32'h04, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
        apb_read(32'h14, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL reset_clkdiv got=%h exp=4", d); end
        apb_read(32'h0C, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_rxdata got=%h exp=0", d); end
        apb_write(32'h08, 32'h0000_0011);
        apb_write(32'h3C, 32'hFFFF_FFFF);
        apb_read(32'h08, d);
        checks++; if (d !== 32'h11) begin failures++; $display("FAIL unmapped_write got=%h exp=11", d); end
        apb_read(32'h24, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
    endtask

    task automatic test_gpio();
        logic [31:0] d;
        apb_write(32'h18, 32'hF);
        apb_write(32'h1C, 32'hA);
        @(posedge clk); #1;
        checks++; if (gpio !== 4'b1010) begin failures++; $display("FAIL gpio_drive got=%b exp=1010", gpio); end
        apb_read(32'h18, d);
        checks++; if (d !== 32'hF) begin failures++; $display("FAIL gpio_oe_rb got=%h exp=f", d); end
        apb_write(32'h18, 32'h0);
        ext_val = 4'h5;
        ext_en  = 1'b1;
        repeat (3) @(posedge clk);
        apb_read(32'h20, d);
        checks++; if (d !== 32'h5) begin failures++; $display("FAIL gpio_in got=%h exp=5", d); end
        ext_en = 1'b0;
    endtask

    task automatic test_two_byte();
        logic [31:0] d;
        int r, w, mn, mx;
        bit to, e, a;
        prep_xfer(16'd4, 2'd1, 32'h00B3_456D, 32'h1234_5679);
        apb_write(32'h00, 32'h1);
        checks++; if (cs_n !== 1'b0) begin failures++; $display("FAIL two_cs_low got=%b exp=0", cs_n); end
        fork
            watch_xfer(400, 2, r, w, mn, mx, to);
            begin
                apb_read(32'h04, d);
                checks++; if (d !== 32'h1) begin failures++; $display("FAIL two_busy got=%h exp=1", d); end
            end
        join
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL two_timeout got=%b exp=0", to); end
        checks++; if (r != 16) begin failures++; $display("FAIL two_rises got=%0d exp=16", r); end
        checks++; if (w != 1) begin failures++; $display("FAIL two_windows got=%0d exp=1", w); end
        checks++; if (mn != 8 || mx != 8) begin failures++; $display("FAIL two_period got=%0d..%0d exp=8", mn, mx); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin failures++; $display("FAIL two_mosi got=%b exp=%b", a, e); end
        end
        apb_read(32'h04, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL two_idle got=%h exp=0", d); end
        apb_read(32'h0C, d);
        checks++; if (d !== 32'h1234) begin failures++; $display("FAIL two_rx got=%h exp=1234", d); end
    endtask

    task automatic test_one_byte_div0();
        logic [31:0] d;
        int r, w, mn, mx;
        bit to, e, a;
        prep_xfer(16'd0, 2'd0, 32'h0000_00C3, 32'h1234_5679);
        apb_write(32'h00, 32'h1);
        watch_xfer(200, 2, r, w, mn, mx, to);
        checks++; if (to !== 1'b0 || r != 8) begin failures++; $display("FAIL div0_rises got=%0d to=%b exp=8", r, to); end
        checks++; if (mn != 2 || mx != 2) begin failures++; $display("FAIL div0_period got=%0d..%0d exp=2", mn, mx); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin failures++; $display("FAIL div0_mosi got=%b exp=%b", a, e); end
        end
        apb_read(32'h0C, d);
        checks++; if (d !== 32'h12) begin failures++; $display("FAIL div0_rx got=%h exp=12", d); end
    endtask

    task automatic test_four_byte();
        logic [31:0] d;
        int r, w, mn, mx;
        bit to, e, a;
        prep_xfer(16'd1, 2'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        apb_write(32'h00, 32'h1);
        watch_xfer(300, 2, r, w, mn, mx, to);
        checks++; if (to !== 1'b0 || r != 32) begin failures++; $display("FAIL four_rises got=%0d to=%b exp=32", r, to); end
        checks++; if (mn != 2 || mx != 2) begin failures++; $display("FAIL four_period got=%0d..%0d exp=2", mn, mx); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin failures++; $display("FAIL four_mosi got=%b exp=%b", a, e); end
        end
        apb_read(32'h0C, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL four_rx got=%h exp=ffffffff", d); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] d;
        int r, w, mn, mx;
        bit to, e, a;
        prep_xfer(16'd2, 2'd1, 32'h0000_BEEF, 32'h1234_5679);
        apb_write(32'h00, 32'h1);
        fork
            watch_xfer(500, 30, r, w, mn, mx, to);
            begin
                apb_write(32'h08, 32'h0000_1234);
                apb_write(32'h00, 32'h1);
                apb_write(32'h10, 32'h3);
                apb_read(32'h04, d);
                checks++; if (d !== 32'h1) begin failures++; $display("FAIL busy_status got=%h exp=1", d); end
            end
        join
        checks++; if (to !== 1'b0 || r != 16) begin failures++; $display("FAIL busy_rises got=%0d to=%b exp=16", r, to); end
        checks++; if (w != 1) begin failures++; $display("FAIL busy_windows got=%0d exp=1", w); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin failures++; $display("FAIL busy_mosi got=%b exp=%b", a, e); end
        end
        apb_read(32'h0C, d);
        checks++; if (d !== 32'h1234) begin failures++; $display("FAIL busy_rx got=%h exp=1234", d); end
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] d;
        int r, w, mn, mx;
        bit to, e, a;
        prep_xfer(16'd4, 2'd3, 32'hFFFF_FFFF, 32'h1234_5679);
        apb_write(32'h00, 32'h1);
        repeat (20) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_cs_n got=%b exp=1", cs_n); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rstmid_sclk got=%b exp=0", sclk); end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        apb_read(32'h04, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rstmid_busy got=%h exp=0", d); end
        apb_read(32'h14, d);
        checks++; if (d !== 32'h4) begin failures++; $display("FAIL rstmid_clkdiv got=%h exp=4", d); end
        prep_xfer(16'd1, 2'd0, 32'h0000_005A, 32'hFFFF_FFFF);
        apb_write(32'h00, 32'h1);
        watch_xfer(200, 2, r, w, mn, mx, to);
        checks++; if (to !== 1'b0 || r != 8) begin failures++; $display("FAIL rstmid_rises got=%0d to=%b exp=8", r, to); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin failures++; $display("FAIL rstmid_mosi got=%b exp=%b", a, e); end
        end
        apb_read(32'h0C, d);
        checks++; if (d !== 32'hFF) begin failures++; $display("FAIL rstmid_rx got=%h exp=ff", d); end
    endtask

    initial begin
        rstn = 1'b0;
        miso = 1'b0;
        miso_pat = 32'd0;
        ext_en = 1'b0;
        ext_val = 4'h0;
        apb.paddr = 32'd0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = 32'd0;
        test_reset();
        test_gpio();
        test_two_byte();
        test_one_byte_div0();
        test_four_byte();
        test_start_while_busy();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cc1200_spi_apb_top.md
Name: cc1200_spi_apb_top

Overview:
- APB3 slave wrapping a byte-oriented SPI master for the TI CC1200 transceiver, plus a 4-bit GPIO port.
- Software loads the transmit word, byte count and SCLK divider, then pulses start.
- Software polls busy and reads back the received word.
- Single clock domain; sits between the processor APB interconnect and the CC1200 pins.

Parameters:
- None (register map, 32-bit data width and 4 GPIO bits are fixed).

Ports:
- clk  in  1  system clock; APB and SPI logic both run on it.
- rstn  in  1  reset, asynchronous, active-low.
- APB_S_0_paddr  in  32  APB address (byte address, bits [5:2] decoded).
- APB_S_0_psel  in  1  APB select.
- APB_S_0_penable  in  1  APB access phase.
- APB_S_0_pwrite  in  1  1 = write.
- APB_S_0_pwdata  in  32  write data.
- APB_S_0_prdata  out  32  read data.
- APB_S_0_pready  out  1  transfer ready.
- APB_S_0_pslverr  out  1  error, tied 0.
- GPIO  inout  4  general-purpose pins, per-bit tristate.
- SCLK  out  1  SPI clock, mode 0 (idle low).
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in.
- CS_n  out  1  SPI chip select, active low.

Behaviour:
- Clocking/reset: one clock (clk); reset is asynchronous and active-low (rstn).
- Reset values:
  - CS_n=1, SCLK=0, MOSI=0, busy=0.
  - All registers 0 except CLKDIV=4.
  - GPIO outputs tristated.
- APB timing:
  - pready=psel&penable, zero wait states.
  - Writes commit on the clk edge with psel&penable&pwrite.
  - prdata is combinational from paddr whenever psel=1, else 0.
  - pslverr=0.
  - Unmapped reads return 0; unmapped writes are ignored.
- Register map (offsets):
  - 0x00 CTRL W: writing bit0=1 issues a one-clk start pulse; reads as 0.
  - 0x04 STATUS R: bit0=busy.
  - 0x08 TXDATA RW: 32-bit transmit word.
  - 0x0C RXDATA R: 32-bit received word.
  - 0x10 NBYTE RW [1:0]: transfer length is NBYTE+1 bytes (1..4).
  - 0x14 CLKDIV RW [15:0]: SCLK half-period in clk cycles; 0 is treated as 1.
  - 0x18 GPIO_OE RW [3:0]: 1 = pin driven.
  - 0x1C GPIO_OUT RW [3:0]: drive value.
  - 0x20 GPIO_IN R [3:0]: live pin values, synchronised through 2 flops.
- Start handling: start while busy=1 is ignored. Start while idle:
  - latches TXDATA, NBYTE and CLKDIV into shadow copies;
  - sets busy on the next edge;
  - clears RXDATA.
  - Register writes made during a transfer do not affect it.
- SPI FSM states:
  - IDLE -> SETUP: CS_n=0, first MOSI bit presented, wait 1 half-period.
  - SETUP -> SHIFT: L=8*(NBYTE+1) SCLK cycles.
  - SHIFT -> HOLD: CS_n still low, wait 1 half-period after the last falling edge.
  - HOLD -> IDLE: CS_n=1, busy=0.
- Transmit order: MSB first, starting at bit L-1 of the latched TXDATA. Example: NBYTE=1 sends TXDATA[15:0].
- Mode 0 timing: MISO is sampled on SCLK rising; MOSI changes after SCLK falling.
- Receive: RXDATA shifts left, LSB in, so the last L received bits are right-aligned. Upper bits are 0 when L<32.
- SCLK period is 2*CLKDIV clk cycles. SCLK is low in SETUP, HOLD and IDLE.
- busy rises the clk edge after the start write and falls in the same edge CS_n rises.
- Simultaneous start write and transfer completion: start is ignored (busy still 1).
- Reset mid-transfer immediately forces reset values; the transfer is aborted, nothing is preserved.
- GPIO pin i = GPIO_OE[i] ? GPIO_OUT[i] : Z.

Test Plan:
- Reset: rstn low then high -> CS_n=1, SCLK=0, STATUS=0, read 0x14=4, read 0x0C=0.
- GPIO loopback: write 0x18=0xF, 0x1C=0xA -> pins=1010. Then write 0x18=0, external drive 0x5 -> read 0x20=0x5 (after 2-clk sync).
- 2-byte transfer:
  - Setup: 0x14=4, 0x10=1, 0x08=0x00B3456D, 0x00=1, MISO driven from rotating 0x12345679 shifted on SCLK falling.
  - Expected pins: busy=1 within 1 clk; CS_n low for 16 SCLK cycles of 8 clk each; MOSI bits 0x456D MSB first.
  - Expected result: busy returns 0; read 0x0C = first 16 MISO bits, 0x1234.
- 4-byte transfer with CLKDIV=1, TX=0xA5A5A5A5, MISO tied 1 -> 32 SCLK periods of 2 clk; RXDATA=0xFFFFFFFF.
- Start while busy plus TXDATA rewrite mid-transfer -> second start ignored; MOSI continues with the latched word; exactly one CS_n low window.
- Reset asserted mid-transfer -> CS_n=1, SCLK=0, busy=0 immediately. A new start afterwards completes normally.
